// File: rtl/neighbor_counter.sv
// neighbor_counter
//   Walks every cell of the board once per start and writes a 4-bit count per
//   cell into the count memory: 0..8 adjacent mines, or 4'hF if the cell
//   itself is a mine.
//   Each cell takes 11 cycles. Slots 0..8 present the center and its eight
//   neighbours to the 1-cycle-latency mine memory. Data are sampled one slot
//   later. Slot 9 takes the last sample, and slot 10 is the write pulse.
// Ports
//   clk           system clock
//   rst           asynchronous reset, active-low
//   start         level, sampled only in IDLE
//   mine_rd_addr  mine memory read address (registered)
//   mine_rd_data  mine memory read data, valid 1 cycle after address
//   cnt_mem_addr  count memory write address
//   cnt_mem_in    count memory write data
//   cnt_mem_wren  count memory write enable, one pulse per cell
//   busy          scan in progress
//   done          scan finished, held until reset
module neighbor_counter #(
  parameter int ROWS   = 16,
  parameter int COLS   = 16,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic [ADDR_W-1:0] mine_rd_addr,
  input  logic              mine_rd_data,
  output logic [ADDR_W-1:0] cnt_mem_addr,
  output logic [3:0]        cnt_mem_in,
  output logic              cnt_mem_wren,
  output logic              busy,
  output logic              done
);

  localparam logic [ADDR_W-1:0] LAST_CELL = ADDR_W'(ROWS * COLS - 1);
  localparam logic [ADDR_W-1:0] LAST_COL  = ADDR_W'(COLS - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SCAN  = 2'd1,
    S_WRITE = 2'd2,
    S_DONES = 2'd3
  } state_t;

  state_t            r_state, w_state_nxt;
  logic [ADDR_W-1:0] r_cell, r_row, r_col;
  logic [3:0]        r_slot, r_acc;
  logic              r_is_mine, r_prev_valid;
  logic [ADDR_W-1:0] r_rd_addr, r_wr_addr;
  logic [3:0]        r_wr_data;
  logic              r_wren;

  logic              w_cur_valid, w_hit, w_last;
  logic [ADDR_W-1:0] w_nxt_rd_addr;
  logic [3:0]        w_acc_nxt;

  // Neighbour offset for a read slot, packed as {row+1, col+1}.
  // Order: center, NW, N, NE, W, E, SW, S, SE.
  function automatic logic [3:0] nb_off(input logic [3:0] slot);
    case (slot)
      4'd1:    nb_off = 4'b00_00;
      4'd2:    nb_off = 4'b00_01;
      4'd3:    nb_off = 4'b00_10;
      4'd4:    nb_off = 4'b01_00;
      4'd5:    nb_off = 4'b01_10;
      4'd6:    nb_off = 4'b10_00;
      4'd7:    nb_off = 4'b10_01;
      4'd8:    nb_off = 4'b10_10;
      default: nb_off = 4'b01_01;
    endcase
  endfunction

  // Only in-bounds neighbour reads (slots 1..8) are valid.
  // Rows and columns are checked separately, so column 0 never wraps onto the previous row.
  function automatic logic nb_valid(input logic [ADDR_W-1:0] row, col, input logic [3:0] slot);
    logic [3:0] off;
    int nr, nc;
    off = nb_off(slot);
    nr  = int'(row) + int'(off[3:2]) - 1;
    nc  = int'(col) + int'(off[1:0]) - 1;
    nb_valid = (slot >= 4'd1) && (slot <= 4'd8) &&
               (nr >= 0) && (nr < ROWS) && (nc >= 0) && (nc < COLS);
  endfunction

  // Invalid slots re-read the center address.
  function automatic logic [ADDR_W-1:0] nb_addr(input logic [ADDR_W-1:0] row, col, input logic [3:0] slot);
    logic [3:0] off;
    int nr, nc;
    off = nb_off(slot);
    nr  = int'(row) + int'(off[3:2]) - 1;
    nc  = int'(col) + int'(off[1:0]) - 1;
    if (nb_valid(row, col, slot)) nb_addr = ADDR_W'(nr * COLS + nc);
    else                          nb_addr = ADDR_W'(int'(row) * COLS + int'(col));
  endfunction

  always_comb begin
    w_cur_valid   = nb_valid(r_row, r_col, r_slot);
    w_nxt_rd_addr = nb_addr(r_row, r_col, r_slot + 4'd1);
    // Slot s+1 samples the read issued in slot s. Neighbour samples land in slots 2..9.
    w_hit         = (r_slot >= 4'd2) && r_prev_valid && mine_rd_data;
    w_acc_nxt     = r_acc + {3'b000, w_hit};
    w_last        = (r_cell == LAST_CELL);
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (start) w_state_nxt = S_SCAN;
      S_SCAN:  if (r_slot == 4'd9) w_state_nxt = S_WRITE;
      S_WRITE: w_state_nxt = w_last ? S_DONES : S_SCAN;
      S_DONES: w_state_nxt = S_DONES;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cell       <= '0;
      r_row        <= '0;
      r_col        <= '0;
      r_slot       <= '0;
      r_acc        <= '0;
      r_is_mine    <= 1'b0;
      r_prev_valid <= 1'b0;
      r_rd_addr    <= '0;
      r_wr_addr    <= '0;
      r_wr_data    <= '0;
      r_wren       <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_cell       <= '0;
            r_row        <= '0;
            r_col        <= '0;
            r_slot       <= '0;
            r_acc        <= '0;
            r_is_mine    <= 1'b0;
            r_prev_valid <= 1'b0;
            r_rd_addr    <= '0;
          end
        end
        S_SCAN: begin
          r_slot       <= r_slot + 4'd1;
          r_prev_valid <= w_cur_valid;
          // The address register is loaded one cycle early.
          // This keeps the address for slot s on the bus throughout slot s.
          r_rd_addr    <= w_nxt_rd_addr;
          if (r_slot == 4'd0) r_acc <= '0;
          else                r_acc <= w_acc_nxt;
          if (r_slot == 4'd1) r_is_mine <= mine_rd_data;
          if (r_slot == 4'd9) begin
            r_wren    <= 1'b1;
            r_wr_addr <= r_cell;
            r_wr_data <= r_is_mine ? 4'hF : w_acc_nxt;
          end
        end
        S_WRITE: begin
          r_wren <= 1'b0;
          if (!w_last) begin
            r_cell    <= r_cell + 1'b1;
            r_slot    <= '0;
            r_rd_addr <= r_cell + 1'b1;
            if (r_col == LAST_COL) begin
              r_col <= '0;
              r_row <= r_row + 1'b1;
            end else begin
              r_col <= r_col + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign mine_rd_addr = r_rd_addr;
  assign cnt_mem_addr = r_wr_addr;
  assign cnt_mem_in   = r_wr_data;
  assign cnt_mem_wren = r_wren;
  assign busy         = (r_state == S_SCAN) || (r_state == S_WRITE);
  assign done         = (r_state == S_DONES);

endmodule
